uart_rx_buffer: RTL

// - Receive-side counterpart of the CPU->UART TX buffering: collects bytes from one UART receiver and

---
 rtl/uart_rx_buffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: packs received bytes little-endian into 32-bit words, queues them in a FIFO
// and serves DATA/STATUS registers on the peripheral read bus. Optional partial-word flush: UART_RX_TIMEOUT_EN.
module uart_rx_buffer #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          TIMEOUT_CYC = 1250
) (
  input  logic        clk_125,
  input  logic        rst_125,
  input  logic        uart_mon_rx_en,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  input  logic [31:0] peripheral_addr_in,
  input  logic        peripheral_read_en,
  output logic [31:0] peripheral_data_out,
  output logic        peripheral_data_out_en,
  output logic        uart_rx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_rx_buffer: DEPTH must be a power of 2 >= 4 and TIMEOUT_CYC >= 1");
  end

  typedef struct packed {
    logic [2:0]  cnt;
    logic [31:0] word;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [23:0]   pack;      // the 4th byte never lands here: it is pushed straight into the FIFO
  logic [1:0]    pack_cnt;
  logic          overflow;

  logic   byte_in, flush, push_req, push_ok, pop;
  logic   rd_data, rd_status, empty, full;
  entry_t push_entry, head;
  logic [31:0] status_word;

  assign byte_in   = uart_mon_rx_en && uart_rx_valid;
  assign rd_data   = peripheral_read_en && (peripheral_addr_in == BASE_ADDR);
  assign rd_status = peripheral_read_en && (peripheral_addr_in == BASE_ADDR + 32'd4);
  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign head      = mem[rd_ptr];
  assign pop       = rd_data && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push_req && (!full || pop);

  assign status_word = {overflow, empty, full, 2'b00, (empty ? 3'd0 : head.cnt), 8'h00, 16'(level)};
  assign uart_rx_overflow = overflow;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    push_req   = 1'b0;
    push_entry = '0;
    if (byte_in && pack_cnt == 2'd3) begin
      push_req   = 1'b1;
      push_entry = '{cnt: 3'd4, word: {uart_rx_data, pack}};
    end else if (flush) begin
      push_req   = 1'b1;
      push_entry = '{cnt: {1'b0, pack_cnt}, word: {8'h00, pack}};
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] idle_cnt;
  logic          idle;

  // A byte in the expiry cycle makes the cycle non-idle, so appending wins over flushing.
  assign idle  = uart_mon_rx_en && !uart_rx_valid && (pack_cnt != 2'd0);
  assign flush = idle && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk_125) begin
    if (rst_125 || !idle || flush) idle_cnt <= '0;
    else                           idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign flush = 1'b0;
`endif

  // NOTE: the storage array has no reset; only pointers and level define which entries are valid.
  always_ff @(posedge clk_125) begin
    if (push_ok && !rst_125) mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_125) begin
    if (rst_125) begin
      pack                   <= '0;
      pack_cnt               <= '0;
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      level                  <= '0;
      overflow               <= 1'b0;
      peripheral_data_out    <= '0;
      peripheral_data_out_en <= 1'b0;
    end else begin
      if (!uart_mon_rx_en || flush || (byte_in && pack_cnt == 2'd3)) begin
        pack     <= '0;
        pack_cnt <= '0;
      end else if (byte_in) begin
        pack[{pack_cnt, 3'b000} +: 8] <= uart_rx_data;
        pack_cnt                      <= pack_cnt + 2'd1;
      end

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Setting takes priority over the clear-on-read of STATUS.
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (rd_status)       overflow <= 1'b0;

      if (rd_data) begin
        peripheral_data_out    <= empty ? 32'h0 : head.word;
        peripheral_data_out_en <= 1'b1;
      end else if (rd_status) begin
        peripheral_data_out    <= status_word;
        peripheral_data_out_en <= 1'b1;
      end else begin
        peripheral_data_out_en <= 1'b0;
      end
    end
  end

endmodule
